// File: rtl/axi4_aw_sender_mq_pkg.sv
// Shared types for the RAB miss-queue senders (AW and AR).
// The per-entry payload struct depends on ID/user widths chosen by the
// instantiating module, so it is provided as a typedef macro that wraps
// the fixed-width attribute struct below.
`ifndef AXI4_RAB_MQ_PKG_SV
`define AXI4_RAB_MQ_PKG_SV

package axi4_rab_mq_pkg;

    // Fixed-width AXI4 request attributes carried alongside id/user.
    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [2:0] prot;
        logic [3:0] cache;
        logic [3:0] region;
        logic [3:0] qos;
    } aw_attr_t;

    // Which source drives the master port in a given cycle.
    typedef enum logic {
        GNT_L1 = 1'b0,
        GNT_L2 = 1'b1
    } gnt_sel_t;

    // Bit width able to index n items, never narrower than one bit.
    function automatic int unsigned min1_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// Queue entry payload: id, fixed attributes, user. No address is stored;
// the L2 TLB supplies the translated address when the entry is sent.
`define AXI4_RAB_AW_META_T(IDW, UW) struct packed { logic [(IDW)-1:0] id; axi4_rab_mq_pkg::aw_attr_t attr; logic [(UW)-1:0] user; }

`endif

// File: rtl/axi4_aw_sender_mq_if.sv
// AXI4 write-address channel bundle. The slave side (towards the L1 lookup)
// has no address; the translated address is added on the master side.
interface axi4_aw_sender_mq_if #(
    parameter int ADDR_W = 40,
    parameter int ID_W   = 4,
    parameter int USER_W = 4
);
    import axi4_rab_mq_pkg::*;

    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [2:0]        prot;
    logic [3:0]        cache;
    logic [3:0]        region;
    logic [3:0]        qos;
    logic [USER_W-1:0] user;
    logic              valid;
    logic              ready;

    modport master (
        output id, addr, len, size, burst, lock, prot, cache, region, qos, user, valid,
        input  ready
    );

    modport slave (
        input  id, len, size, burst, lock, prot, cache, region, qos, user, valid,
        output ready
    );

endinterface

// File: rtl/rab_meta_fifo.sv
// In-order metadata FIFO with combinational head output. Depth need not be
// a power of two; pointers wrap explicitly at DEPTH-1. Push is ignored when
// full and pop when empty; full/empty are purely registered (no bypass).
module rab_meta_fifo
    import axi4_rab_mq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W    = min1_clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             do_push;
    logic             do_pop;
    logic [DEPTH-1:0] wr_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem_reg[rd_ptr_reg];

    // One write-enable per slot, decoded from the write pointer.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // Next pointer and occupancy; simultaneous push/pop keeps the count.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (do_push) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (do_pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Entry storage, cleared on reset so a stale head never leaks out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    mem_reg[i] <= push_data;
                end
            end
        end
    end

endmodule

// File: rtl/axi4_aw_sender_mq.sv
// RAB AW-channel sender with an in-order L1-miss queue. L1 hits pass
// straight to the master port; L1 misses are parked until the L2 TLB either
// translates the head entry (sent with l2_awaddr_i) or drops it. A sticky
// busy flag keeps an L2 send on the master port until it handshakes.
module axi4_aw_sender_mq
    import axi4_rab_mq_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 40,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 4,
    parameter int L2_DEPTH       = 4,
    parameter int L2_PRIO        = 1,
    parameter int MAX_L1_WAIT    = 8,
    localparam int CNT_W = $clog2(L2_DEPTH + 1)
) (
    input  logic                      axi4_aclk,
    input  logic                      axi4_arstn,

    output logic                      l1_done_o,
    input  logic                      l1_accept_i,
    input  logic                      l1_drop_i,
    input  logic                      l1_save_i,

    output logic                      l2_done_o,
    input  logic                      l2_accept_i,
    input  logic                      l2_drop_i,
    output logic                      l2_sending_o,
    output logic                      l2_head_valid_o,
    output logic [AXI_ID_WIDTH-1:0]   l2_head_id_o,
    output logic [CNT_W-1:0]          l2_count_o,
    output logic                      l2_full_o,

    input  logic [AXI_ADDR_WIDTH-1:0] l1_awaddr_i,
    input  logic [AXI_ADDR_WIDTH-1:0] l2_awaddr_i,

    axi4_aw_sender_mq_if.slave        s_axi4_aw,
    axi4_aw_sender_mq_if.master       m_axi4_aw
);

    typedef `AXI4_RAB_AW_META_T(AXI_ID_WIDTH, AXI_USER_WIDTH) aw_meta_t;

    localparam int META_W = $bits(aw_meta_t);
    localparam int WAIT_W = min1_clog2(MAX_L1_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_L1_WAIT);

    aw_meta_t                  slave_meta;
    aw_meta_t                  head_meta;
    aw_meta_t                  out_meta;
    logic [META_W-1:0]         head_bits;
    logic [AXI_ADDR_WIDTH-1:0] out_addr;
    logic                      head_valid;
    logic                      queue_empty;
    logic                      queue_full;
    logic [CNT_W-1:0]          queue_count;
    logic                      l1_req;
    logic                      l1_go;
    logic                      sending;
    logic                      push;
    logic                      pop;
    gnt_sel_t                  gnt_sel;
    logic                      l2_busy_reg, l2_busy_next;
    logic [WAIT_W-1:0]         wait_cnt_reg, wait_cnt_next;

    // Slave request packed as a queue entry.
    assign slave_meta.id          = s_axi4_aw.id;
    assign slave_meta.attr.len    = s_axi4_aw.len;
    assign slave_meta.attr.size   = s_axi4_aw.size;
    assign slave_meta.attr.burst  = s_axi4_aw.burst;
    assign slave_meta.attr.lock   = s_axi4_aw.lock;
    assign slave_meta.attr.prot   = s_axi4_aw.prot;
    assign slave_meta.attr.cache  = s_axi4_aw.cache;
    assign slave_meta.attr.region = s_axi4_aw.region;
    assign slave_meta.attr.qos    = s_axi4_aw.qos;
    assign slave_meta.user        = s_axi4_aw.user;

    rab_meta_fifo #(
        .WIDTH (META_W),
        .DEPTH (L2_DEPTH)
    ) u_miss_fifo (
        .clk       (axi4_aclk),
        .rst_n     (axi4_arstn),
        .push      (push),
        .pop       (pop),
        .push_data (slave_meta),
        .head_data (head_bits),
        .full      (queue_full),
        .empty     (queue_empty),
        .count     (queue_count)
    );

    assign head_meta  = aw_meta_t'(head_bits);
    assign head_valid = ~queue_empty;
    assign l1_req     = s_axi4_aw.valid & l1_accept_i;

    // Master-port arbitration: an L2 send in flight always keeps the port;
    // otherwise L2 wins by priority or once L1 has starved it long enough.
    always_comb begin
        gnt_sel = GNT_L2;
        if (!l2_busy_reg && l1_req) begin
            if (L2_PRIO != 0) begin
                gnt_sel = GNT_L2;
            end else if (wait_cnt_reg == WAIT_MAX) begin
                gnt_sel = GNT_L2;
            end else begin
                gnt_sel = GNT_L1;
            end
        end
    end

    assign sending = l2_accept_i & head_valid & (gnt_sel == GNT_L2);
    assign l1_go   = l1_req & ~sending;
    assign push    = s_axi4_aw.valid & l1_save_i & ~queue_full;
    assign pop     = (sending & m_axi4_aw.ready) | (head_valid & l2_drop_i);

    // Master payload mux: head entry with L2 address, or slave with L1 address.
    always_comb begin
        out_meta = slave_meta;
        out_addr = l1_awaddr_i;
        if (sending) begin
            out_meta = head_meta;
            out_addr = l2_awaddr_i;
        end
    end

    assign m_axi4_aw.valid  = sending | l1_go;
    assign m_axi4_aw.addr   = out_addr;
    assign m_axi4_aw.id     = out_meta.id;
    assign m_axi4_aw.len    = out_meta.attr.len;
    assign m_axi4_aw.size   = out_meta.attr.size;
    assign m_axi4_aw.burst  = out_meta.attr.burst;
    assign m_axi4_aw.lock   = out_meta.attr.lock;
    assign m_axi4_aw.prot   = out_meta.attr.prot;
    assign m_axi4_aw.cache  = out_meta.attr.cache;
    assign m_axi4_aw.region = out_meta.attr.region;
    assign m_axi4_aw.qos    = out_meta.attr.qos;
    assign m_axi4_aw.user   = out_meta.user;

    assign s_axi4_aw.ready = (l1_go & m_axi4_aw.ready)
                           | (s_axi4_aw.valid & l1_drop_i)
                           | (s_axi4_aw.valid & l1_save_i & ~queue_full);

    assign l1_done_o       = s_axi4_aw.valid & s_axi4_aw.ready;
    assign l2_done_o       = pop;
    assign l2_sending_o    = sending;
    assign l2_head_valid_o = head_valid;
    assign l2_head_id_o    = head_valid ? head_meta.id : '0;
    assign l2_count_o      = queue_count;
    assign l2_full_o       = queue_full;

    // Busy latch and L1-starvation counter updates.
    always_comb begin
        l2_busy_next  = l2_busy_reg;
        wait_cnt_next = wait_cnt_reg;
        if (sending) begin
            l2_busy_next = ~m_axi4_aw.ready;
        end
        if (L2_PRIO == 0) begin
            if (!head_valid || sending) begin
                wait_cnt_next = '0;
            end else if (l1_go && m_axi4_aw.ready && l2_accept_i && (wait_cnt_reg != WAIT_MAX)) begin
                wait_cnt_next = wait_cnt_reg + 1'b1;
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            l2_busy_reg  <= 1'b0;
            wait_cnt_reg <= '0;
        end else begin
            l2_busy_reg  <= l2_busy_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Upstream stages must present one-hot decisions.
    a_l1_onehot: assert property (@(posedge axi4_aclk) disable iff (!axi4_arstn)
        $onehot0({l1_accept_i, l1_drop_i, l1_save_i}));
    a_l2_onehot: assert property (@(posedge axi4_aclk) disable iff (!axi4_arstn)
        $onehot0({l2_accept_i, l2_drop_i}));

endmodule

// File: doc/axi4_aw_sender_mq.md
Name: axi4_aw_sender_mq

Overview:
- Next-generation AW-channel sender for the RAB.
- Forwards write-address requests translated by the L1 TLB directly to the master port.
- Parks L1-miss requests in a parametrised in-order miss queue (depth L2_DEPTH) instead of a single L2 slot, so the slave AW channel keeps flowing while the L2 TLB resolves up to L2_DEPTH outstanding misses.
- Sits between the L1 lookup stage and the master AXI4 AW port, alongside the AR-channel counterpart.

Parameters:
- AXI_ADDR_WIDTH, 40, address width.
- AXI_ID_WIDTH, 4, ID width.
- AXI_USER_WIDTH, 4, user width.
- L2_DEPTH, 4, miss-queue entries; any value >=1; need not be a power of 2.
- L2_PRIO, 1, 1 = queued L2 send beats a simultaneous L1 pass-through; 0 = L1 first, but the L2 head wins after MAX_L1_WAIT consecutive L1 grants.
- MAX_L1_WAIT, 8, starvation bound used only when L2_PRIO=0.

Ports:
- axi4_aclk  in  1  clock
- axi4_arstn  in  1  async reset, active low
- l1_done_o  out  1  slave AW handshake completed this cycle
- l1_accept_i  in  1  L1 hit, forward request
- l1_drop_i  in  1  L1 says drop (protection fault)
- l1_save_i  in  1  L1 miss, park in queue
- l2_done_o  out  1  head entry retired (sent or dropped)
- l2_accept_i  in  1  L2 hit for head entry
- l2_drop_i  in  1  L2 miss/fault for head entry, discard it
- l2_sending_o  out  1  master port is currently driven by the head entry
- l2_head_valid_o  out  1  queue non-empty
- l2_head_id_o  out  AXI_ID_WIDTH  ID of head entry (for L2 miss reporting)
- l2_count_o  out  $clog2(L2_DEPTH+1)  queue occupancy
- l2_full_o  out  1  occupancy == L2_DEPTH
- l1_awaddr_i  in  AXI_ADDR_WIDTH  L1-translated address
- l2_awaddr_i  in  AXI_ADDR_WIDTH  L2-translated address for head
- s_axi4_aw*  slave AW channel: id, valid(in), ready(out), len 8, size 3, burst 2, lock 1, prot 3, cache 4, region 4, qos 4, user
- m_axi4_aw*  master AW channel: same fields plus addr; valid(out), ready(in)

Behaviour:
- Clock is axi4_aclk; reset is axi4_arstn, asynchronous and active-low. Reset: rd/wr pointers 0, count 0, arbitration counter 0, stored entries 0.
- All outputs are combinational from state and inputs; with idle inputs after reset, every output is 0.
- Entry payload: id, len, size, burst, lock, prot, cache, region, qos, user. No address is stored; L2 supplies it.
- l2_sending_o = l2_accept_i & head_valid & grant_l2.
  - grant_l2 = 1 when no L1 accept is pending (s_axi4_awvalid & l1_accept_i == 0).
  - Otherwise grant_l2 = L2_PRIO, or (wait_cnt == MAX_L1_WAIT) when L2_PRIO=0.
- m_axi4_awvalid = l2_sending_o | (s_axi4_awvalid & l1_accept_i & ~l2_sending_o).
- Master AW fields come from the head entry plus l2_awaddr_i when l2_sending_o; otherwise from the slave fields plus l1_awaddr_i.
- s_axi4_awready = (s_axi4_awvalid & l1_accept_i & ~l2_sending_o & m_axi4_awready) | (s_axi4_awvalid & l1_drop_i) | (s_axi4_awvalid & l1_save_i & ~full_q).
- Save while full: awready stays low and the request stalls; no overwrite, no loss.
- push = s_axi4_awvalid & l1_save_i & ~full_q.
- pop = (l2_sending_o & m_axi4_awready) | (head_valid & l2_drop_i).
- l2_drop_i with an empty queue is ignored.
- Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full and empty are judged on registered state only; there is no bypass.
  - A push into an empty queue is not sendable until the next cycle.
- Pointers wrap from L2_DEPTH-1 to 0.
- l2_done_o = pop. l1_done_o = s_axi4_awvalid & s_axi4_awready.
- AXI stability: once m_axi4_awvalid rises under l2_sending_o, it must hold until m_axi4_awready.
  - The grant is therefore latched: a sticky l2_busy_q is set on l2_sending_o & ~m_axi4_awready and cleared on the handshake.
  - While l2_busy_q is set, grant_l2 is forced to 1.
- wait_cnt (L2_PRIO=0 only):
  - Increments on each L1 master handshake while head_valid & l2_accept_i.
  - Resets to 0 on an L2 send, or when the queue is empty.
  - Saturates at MAX_L1_WAIT.
- Mutually exclusive inputs (l1_accept/drop/save one-hot; l2_accept/drop one-hot) are checked by assertion only.

Decomposition:
- Package axi4_rab_mq_pkg:
  - aw_meta_t packed struct (entry payload, parametrised via widths passed at use site, or a typedef macro).
  - Grant-select enum {GNT_L1, GNT_L2}.
- One sub-module, rab_meta_fifo: generic depth-parametrised FIFO with push/pop/full/empty/count and head data output, also reused by the AR sender.

Test Plan:
- L1 hit, L2_DEPTH=4: awvalid=1, l1_accept=1, l1_awaddr=0x1000, m_awready=1 -> m_awaddr=0x1000, l1_done_o=1 the same cycle, count stays 0.
- Four saves with IDs 1,2,3,4 -> count=4, full=1. Fifth save with ID 5 -> s_awready=0 for 3 cycles. Then l2_accept with l2_awaddr=0xA000 -> ID1 sent at 0xA000, next cycle ID5 accepted, count returns to 4.
- l2_drop on head ID2 -> l2_done_o=1, m_awvalid=0, head_id becomes 3.
- Contention with L2_PRIO=1: L1 hit and L2 head both ready -> L2 sent first, s_awready=0, L1 sent the next cycle.
- Contention with L2_PRIO=0, MAX_L1_WAIT=2: continuous L1 hits with the L2 head ready -> two L1 grants, then the L2 head wins on the third.
- Back-pressure plus reset: L2 send with m_awready=0 for 5 cycles -> fields stable, l2_busy held. Assert axi4_arstn=0 mid-stall -> count=0, all outputs 0, no spurious send after release.
